pcm_sample_fifo: RTL and testbench

//  Stereo PCM sample buffer directly upstream of the i2s serializer.
//  The decoder pushes one stereo frame per handshake: two 17-bit channel words plus a
//  2-bit chansgn stereo-decorrelation code. The i2s block pops frames via the phy_rd_* interface.

---
 rtl/pcm_sample_fifo.sv | 170 +++++++++++++++++
 tb/tb_pcm_sample_fifo.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcm_sample_fifo.sv
// Stereo PCM frame FIFO feeding the i2s serializer, with first-word fall-through read side
// and an EVB register port (CTRL at 0, THRESH at 1). EVB mask codes: 0 DUMMY, 1 L, 2 H, 3 W.
module pcm_sample_fifo #(
  parameter int unsigned DEPTH_LOG2 = 6,
  parameter int unsigned DATA_W     = 17
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_valid_i,
  output logic              wr_ready_o,
  input  logic [1:0]        wr_chansgn_i,
  input  logic [DATA_W-1:0] wr_data_chan0_i,
  input  logic [DATA_W-1:0] wr_data_chan1_i,
  output logic              phy_rd_valid_o,
  input  logic              phy_rd_i,
  output logic [1:0]        phy_rd_chansgn_o,
  output logic [DATA_W-1:0] phy_rd_data_chan0_o,
  output logic [DATA_W-1:0] phy_rd_data_chan1_o,
  input  logic              evb_cmd_request_i,
  input  logic [3:0]        evb_cmd_addr_i,
  input  logic [1:0]        evb_cmd_wr_mask_i,
  input  logic [31:0]       evb_cmd_wr_data_i,
  output logic              evb_cmd_finish_o,
  output logic [31:0]       evb_cmd_rd_data_o,
  output logic              low_water_o
);

  localparam int unsigned Depth  = 1 << DEPTH_LOG2;
  localparam int unsigned LvlW   = DEPTH_LOG2 + 1;
  localparam int unsigned EntryW = 2 + 2 * DATA_W;

  localparam logic [LvlW-1:0] LevelFull = LvlW'(Depth);

  localparam logic [1:0] MaskDummy = 2'd0;
  localparam logic [1:0] MaskL     = 2'd1;
  localparam logic [1:0] MaskH     = 2'd2;
  localparam logic [1:0] MaskW     = 2'd3;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StAck  = 2'd1;
  localparam logic [1:0] StGap  = 2'd2;

  logic [EntryW-1:0]     mem [Depth];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]       level_q, level_d, thresh_q, thresh_d;
  logic                  enable_q, enable_d, underrun_q, underrun_d;
  logic [1:0]            state_q, state_d;
  logic [31:0]           rd_data_q, rd_data_d;
  logic                  wr_ready_q, rd_valid_q, low_water_q;

  logic [31:0] level_ext, ctrl_val, reg_val, merged;
  logic        accept, lo_wr, ctrl_wr, thresh_wr, flush, uclr, uset, push, pop;
  logic [EntryW-1:0] head;
  logic        unused_bits;

  assign level_ext = 32'(level_q);
  assign ctrl_val  = {16'h0, level_ext[7:0], 5'h0, underrun_q, 1'b0, enable_q};

  always_comb begin
    reg_val = '0;
    unique case (evb_cmd_addr_i)
      4'd0:    reg_val = ctrl_val;
      4'd1:    reg_val = 32'(thresh_q);
      default: reg_val = '0;
    endcase
  end

  always_comb begin
    merged = reg_val;
    unique case (evb_cmd_wr_mask_i)
      MaskW:     merged = evb_cmd_wr_data_i;
      MaskH:     merged = {evb_cmd_wr_data_i[15:0], reg_val[15:0]};
      MaskL:     merged = {reg_val[31:16], evb_cmd_wr_data_i[15:0]};
      MaskDummy: merged = reg_val;
      default:   merged = reg_val;
    endcase
  end

  // All fields live in the low half, so only masks that write it have side effects;
  // this keeps an H write from replaying the W1C underrun bit.
  assign accept    = evb_cmd_request_i && (state_q == StIdle);
  assign lo_wr     = accept && evb_cmd_wr_mask_i[0];
  assign ctrl_wr   = lo_wr && (evb_cmd_addr_i == 4'd0);
  assign thresh_wr = lo_wr && (evb_cmd_addr_i == 4'd1);
  assign flush     = ctrl_wr && merged[1];
  assign uclr      = ctrl_wr && merged[2];

  assign push = wr_valid_i && wr_ready_q && !flush;
  assign pop  = phy_rd_i && rd_valid_q && !flush;
  assign uset = phy_rd_i && !rd_valid_q && !flush;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + DEPTH_LOG2'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + DEPTH_LOG2'(1) : rd_ptr_q;
    level_d  = level_q;
    if (push && !pop) begin
      level_d = level_q + LvlW'(1);
    end else if (pop && !push) begin
      level_d = level_q - LvlW'(1);
    end
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end
    enable_d   = ctrl_wr ? merged[0] : enable_q;
    thresh_d   = thresh_wr ? merged[LvlW-1:0] : thresh_q;
    underrun_d = (underrun_q && !uclr) || uset;
    rd_data_d  = accept ? reg_val : rd_data_q;
  end

  always_comb begin
    state_d = StIdle;
    unique case (state_q)
      StIdle:  state_d = accept ? StAck : StIdle;
      StAck:   state_d = StGap;
      StGap:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      thresh_q    <= '0;
      enable_q    <= 1'b0;
      underrun_q  <= 1'b0;
      state_q     <= StIdle;
      rd_data_q   <= '0;
      wr_ready_q  <= 1'b0;
      rd_valid_q  <= 1'b0;
      low_water_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      thresh_q    <= thresh_d;
      enable_q    <= enable_d;
      underrun_q  <= underrun_d;
      state_q     <= state_d;
      rd_data_q   <= rd_data_d;
      wr_ready_q  <= enable_d && (level_d != LevelFull);
      rd_valid_q  <= enable_d && (level_d != '0);
      low_water_q <= enable_d && (level_d <= thresh_d);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr_q] <= {wr_chansgn_i, wr_data_chan1_i, wr_data_chan0_i};
    end
  end

  // Outputs read zero whenever no frame is presented.
  assign head = rd_valid_q ? mem[rd_ptr_q] : '0;

  assign wr_ready_o          = wr_ready_q;
  assign phy_rd_valid_o      = rd_valid_q;
  assign phy_rd_chansgn_o    = head[EntryW-1 -: 2];
  assign phy_rd_data_chan1_o = head[2*DATA_W-1 -: DATA_W];
  assign phy_rd_data_chan0_o = head[DATA_W-1:0];
  assign evb_cmd_finish_o    = (state_q == StAck);
  assign evb_cmd_rd_data_o   = rd_data_q;
  assign low_water_o         = low_water_q;

  assign unused_bits = ^{merged, level_ext[31:8]};

endmodule

// File: tb/tb_pcm_sample_fifo.sv
// Bench for pcm_sample_fifo at DEPTH_LOG2 = 2: directed scenarios plus random traffic, all
// outputs compared each cycle against a queue-based model of the FIFO and register file.
module tb_pcm_sample_fifo;
  localparam int unsigned DL    = 2;
  localparam int unsigned DW    = 17;
  localparam int unsigned DEPTH = 4;

  localparam logic [1:0] MD = 2'd0;
  localparam logic [1:0] ML = 2'd1;
  localparam logic [1:0] MH = 2'd2;
  localparam logic [1:0] MW = 2'd3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, wr_valid, wr_ready, phy_rd, phy_rd_valid;
  logic [1:0]    wr_sgn, rd_sgn, mask;
  logic [DW-1:0] wr_c0, wr_c1, rd_c0, rd_c1;
  logic          req, finish, low_water;
  logic [3:0]    addr;
  logic [31:0]   wd, rd_data;

  pcm_sample_fifo #(.DEPTH_LOG2(DL), .DATA_W(DW)) dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .wr_valid_i          (wr_valid),
    .wr_ready_o          (wr_ready),
    .wr_chansgn_i        (wr_sgn),
    .wr_data_chan0_i     (wr_c0),
    .wr_data_chan1_i     (wr_c1),
    .phy_rd_valid_o      (phy_rd_valid),
    .phy_rd_i            (phy_rd),
    .phy_rd_chansgn_o    (rd_sgn),
    .phy_rd_data_chan0_o (rd_c0),
    .phy_rd_data_chan1_o (rd_c1),
    .evb_cmd_request_i   (req),
    .evb_cmd_addr_i      (addr),
    .evb_cmd_wr_mask_i   (mask),
    .evb_cmd_wr_data_i   (wd),
    .evb_cmd_finish_o    (finish),
    .evb_cmd_rd_data_o   (rd_data),
    .low_water_o         (low_water)
  );

  int checks = 0;
  int errors = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: frames as {chansgn, chan1, chan0} in a queue.
  logic [2*DW+1:0] m_q[$];
  logic            m_en, m_und;
  logic [DL:0]     m_thr;
  int              m_phase;
  logic [31:0]     m_rd;
  logic            m_vld, m_rdy, m_acc, m_lo, m_fl, m_clr, m_push, m_pop, m_uset;

  function automatic logic [31:0] m_reg(logic [3:0] a);
    if (a == 4'd0) return {16'h0, 8'(m_q.size()), 5'h0, m_und, 1'b0, m_en};
    if (a == 4'd1) return 32'(m_thr);
    return 32'h0;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_q.delete();
      m_en = 1'b0; m_und = 1'b0; m_thr = '0; m_phase = 0; m_rd = '0;
    end else begin
      m_vld = m_en && (m_q.size() != 0);
      m_rdy = m_en && (m_q.size() != DEPTH);
      m_acc = req && (m_phase == 0);
      m_lo  = m_acc && (mask == MW || mask == ML);
      if (m_acc) m_rd = m_reg(addr);
      m_fl   = m_lo && (addr == 4'd0) && wd[1];
      m_clr  = m_lo && (addr == 4'd0) && wd[2];
      m_pop  = phy_rd && m_vld && !m_fl;
      m_push = wr_valid && m_rdy && !m_fl;
      m_uset = phy_rd && !m_vld && !m_fl;
      if (m_fl) begin
        m_q.delete();
      end else begin
        if (m_pop) void'(m_q.pop_front());
        if (m_push) m_q.push_back({wr_sgn, wr_c1, wr_c0});
      end
      m_und = (m_und && !m_clr) || m_uset;
      if (m_lo && addr == 4'd0) m_en = wd[0];
      if (m_lo && addr == 4'd1) m_thr = wd[DL:0];
      m_phase = m_acc ? 1 : (m_phase == 1 ? 2 : 0);
    end
  end

  logic chk_on = 1'b0;
  always @(negedge clk) begin
    if (chk_on) begin
      logic            ev;
      logic [2*DW+1:0] hd;
      ev = m_en && (m_q.size() != 0);
      hd = ev ? m_q[0] : '0;
      check("wr_ready", wr_ready, m_en && (m_q.size() != DEPTH));
      check("phy_rd_valid", phy_rd_valid, ev);
      check("head_frame", {rd_sgn, rd_c1, rd_c0}, hd);
      check("low_water", low_water, m_en && (m_q.size() <= int'(m_thr)));
      check("evb_finish", finish, m_phase == 1);
      check("evb_rd_data", rd_data, m_rd);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic evb(input logic [3:0] a, input logic [1:0] m, input logic [31:0] d,
                     output logic [31:0] r);
    bit got = 0;
    req = 1'b1; addr = a; mask = m; wd = d; r = '0;
    for (int i = 0; i < 8 && !got; i++) begin
      tick();
      if (finish) begin
        got = 1;
        r = rd_data;
      end
    end
    req = 1'b0;
    if (!got) begin
      checks++; errors++;
      $display("FAIL evb_timeout: finish not seen, expected within 8 cycles");
    end
    tick();
  endtask

  task automatic push(input logic [DW-1:0] c0, input logic [DW-1:0] c1, input logic [1:0] s);
    bit got = 0;
    wr_valid = 1'b1; wr_c0 = c0; wr_c1 = c1; wr_sgn = s;
    for (int i = 0; i < 20 && !got; i++) begin
      if (wr_ready) got = 1;
      tick();
    end
    wr_valid = 1'b0;
    if (!got) begin
      checks++; errors++;
      $display("FAIL push_timeout: wr_ready stayed 0, expected 1 within 20 cycles");
    end
  endtask

  task automatic pop();
    phy_rd = 1'b1;
    tick();
    phy_rd = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1);
  end

  initial begin
    logic [31:0] r;
    bit got;
    rst = 1'b1; wr_valid = 0; phy_rd = 0; wr_sgn = 0; wr_c0 = 0; wr_c1 = 0;
    req = 0; addr = 0; mask = 0; wd = 0;
    repeat (2) tick();
    chk_on = 1'b1;
    check("rst_wr_ready", wr_ready, 0);
    check("rst_valid", phy_rd_valid, 0);
    check("rst_chan0", rd_c0, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_low_water", low_water, 0);
    rst = 1'b0;
    tick();

    // 1) three frames in, one pop every 4 cycles
    evb(4'd0, MW, 32'h1, r);
    for (int i = 0; i < 3; i++) push(DW'(i + 1), DW'(100 + i), 2'd3);
    evb(4'd0, MD, 32'h0, r);
    check("t1_ctrl_level3", r, 32'h0301);
    for (int i = 0; i < 3; i++) begin
      check("t1_chan0", rd_c0, 64'(i + 1));
      check("t1_chansgn", rd_sgn, 3);
      pop();
      repeat (3) tick();
    end
    check("t1_valid_after", phy_rd_valid, 0);
    evb(4'd0, MD, 32'h0, r);
    check("t1_ctrl_level0", r, 32'h0001);

    // 2) fill to DEPTH, 5th frame held until one pop
    for (int i = 0; i < 4; i++) push(DW'(10 + i), DW'(i), 2'(i));
    check("t2_ready_full", wr_ready, 0);
    wr_valid = 1'b1; wr_c0 = DW'(14); wr_c1 = '0; wr_sgn = 2'd1;
    repeat (2) tick();
    check("t2_ready_held", wr_ready, 0);
    evb(4'd0, MD, 32'h0, r);
    check("t2_ctrl_level4", r, 32'h0401);
    pop();
    check("t2_ready_after_pop", wr_ready, 1);
    tick();
    wr_valid = 1'b0;
    check("t2_ready_refull", wr_ready, 0);
    for (int i = 0; i < 4; i++) begin
      check("t2_drain_chan0", rd_c0, 64'(11 + i));
      pop();
    end

    // 3) level 2, simultaneous push and pop across the wrap point
    push(DW'(20), '0, 2'd0);
    push(DW'(21), '0, 2'd0);
    for (int i = 0; i < 3; i++) begin
      check("t3_head", rd_c0, 64'(20 + i));
      wr_valid = 1'b1; wr_c0 = DW'(22 + i); phy_rd = 1'b1;
      tick();
    end
    wr_valid = 1'b0; phy_rd = 1'b0;
    evb(4'd0, MD, 32'h0, r);
    check("t3_ctrl_level2", r, 32'h0201);
    check("t3_tail0", rd_c0, 23);
    pop();
    check("t3_tail1", rd_c0, 24);
    pop();

    // 4) underrun on empty, then W1C
    pop();
    check("t4_valid", phy_rd_valid, 0);
    evb(4'd0, MD, 32'h0, r);
    check("t4_underrun_set", r, 32'h0005);
    evb(4'd0, MW, 32'h5, r);
    evb(4'd0, MD, 32'h0, r);
    check("t4_underrun_clr", r, 32'h0001);

    // 5) low-water threshold and H-mask write
    evb(4'd1, MW, 32'h1, r);
    for (int i = 0; i < 3; i++) push(DW'(30 + i), '0, 2'd2);
    check("t5_lw_level3", low_water, 0);
    pop();
    check("t5_lw_level2", low_water, 0);
    pop();
    check("t5_lw_level1", low_water, 1);
    evb(4'd1, MH, 32'hABCD_0003, r);
    check("t5_h_before", r, 32'h1);
    evb(4'd1, MD, 32'h0, r);
    check("t5_h_keeps_low", r, 32'h1);
    pop();
    check("t5_lw_level0", low_water, 1);

    // 6) flush at level 4 with concurrent push and pop
    for (int i = 0; i < 4; i++) push(DW'(40 + i), '0, 2'd0);
    req = 1'b1; addr = 4'd0; mask = MW; wd = 32'h3;
    wr_valid = 1'b1; wr_c0 = DW'(44); phy_rd = 1'b1;
    tick();
    wr_valid = 1'b0; phy_rd = 1'b0;
    got = 0; r = '0;
    for (int i = 0; i < 8 && !got; i++) begin
      if (finish) begin got = 1; r = rd_data; end
      else tick();
    end
    req = 1'b0;
    tick();
    check("t6_rd_data", r, 32'h0401);
    check("t6_valid", phy_rd_valid, 0);
    evb(4'd0, MD, 32'h0, r);
    check("t6_ctrl_after", r, 32'h0001);

    // disable retains contents
    push(DW'(50), '0, 2'd1);
    push(DW'(51), '0, 2'd1);
    evb(4'd0, MW, 32'h0, r);
    check("t7_valid_dis", phy_rd_valid, 0);
    check("t7_ready_dis", wr_ready, 0);
    evb(4'd0, MW, 32'h1, r);
    check("t7_retained", rd_c0, 50);

    // random traffic
    for (int cyc = 0; cyc < 2000; cyc++) begin
      wr_valid = ($urandom % 10) < 6;
      wr_c0 = DW'($urandom); wr_c1 = DW'($urandom); wr_sgn = 2'($urandom);
      phy_rd = ($urandom % 2) == 0;
      if (!req && ($urandom % 16) == 0) begin
        req = 1'b1; addr = 4'($urandom % 4); mask = 2'($urandom); wd = $urandom;
        if (addr == 4'd0) begin
          wd[0] = ($urandom % 8) != 0;
          wd[1] = ($urandom % 12) == 0;
        end
      end
      rst = ($urandom % 400) == 0;
      if (rst) req = 1'b0;
      tick();
      if (req && finish) req = 1'b0;
    end
    rst = 1'b0; req = 1'b0; wr_valid = 1'b0; phy_rd = 1'b0;
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
